// File: rtl/csa_resolve_pkg.sv
// Shared types and lane helpers for the carry-save resolver.
// Lane geometry is expressed in 32-bit chunks so any future resolver can reuse it.
package csa_resolve_pkg;

  localparam int LEN   = 256;
  localparam int CHUNK = 32;
  localparam int NCH   = LEN / CHUNK;

  typedef logic [LEN-1:0] prng_t;
  typedef logic [NCH-1:0][CHUNK-1:0] prng_split32_t;

  // Packed so that is64 lands on bit 0 of the 3-bit width flags.
  typedef struct packed {
    logic is256;
    logic is128;
    logic is64;
  } width_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } resolve_state_t;

  function automatic logic lane_start(width_t w, logic [2:0] k);
    logic start;
    start = 1'b1;
    if (w.is256) begin
      start = (k == 3'd0);
    end else if (w.is128) begin
      start = (k[1:0] == 2'd0);
    end else if (w.is64) begin
      start = (k[0] == 1'b0);
    end
    return start;
  endfunction

  // Clears the shifted-in carry bit at each lane start so a lane's top sc bit is dropped.
  function automatic prng_t resolve_addend_mask(width_t w);
    prng_t mask;
    mask = '1;
    for (int k = 0; k < NCH; k++) begin
      mask[CHUNK*k] = ~lane_start(w, 3'(k));
    end
    return mask;
  endfunction

endpackage

// File: rtl/csa_resolve_cpa_chunk32.sv
// One 32-bit carry-propagate slice; block_cin suppresses the incoming carry at lane starts.
module cpa_chunk32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        block_cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [32:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {32'd0, cin & ~block_cin};
  assign s    = sum[31:0];
  assign cout = sum[32];

endmodule

// File: rtl/csa_resolve.sv
// Iterative carry-save resolver: collapses (ps, sc) into per-lane binary sums,
// one 32-bit chunk per cycle, then holds the result until the consumer takes it.
module csa_resolve
  import csa_resolve_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [LEN-1:0] ps_i,
  input  logic [LEN-1:0] sc_i,
  input  logic [2:0]     width_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [LEN-1:0] res_o
);

  resolve_state_t state_q, state_d;
  prng_t          ps_q, ps_d;
  prng_t          b_q, b_d;
  prng_t          res_q, res_d;
  width_t         w_q, w_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;

  prng_split32_t  ps_split, b_split, res_split;
  logic [31:0]    chunk_sum;
  logic           chunk_cout;

  assign ps_split = prng_split32_t'(ps_q);
  assign b_split  = prng_split32_t'(b_q);

  cpa_chunk32 u_cpa (
    .a         (ps_split[cnt_q]),
    .b         (b_split[cnt_q]),
    .cin       (carry_q),
    .block_cin (lane_start(w_q, cnt_q)),
    .s         (chunk_sum),
    .cout      (chunk_cout)
  );

  always_comb begin
    state_d     = state_q;
    ps_d        = ps_q;
    b_d         = b_q;
    w_d         = w_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    res_split   = prng_split32_t'(res_q);
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          ps_d       = ps_i;
          b_d        = (sc_i << 1) & resolve_addend_mask(width_t'(width_i));
          w_d        = width_t'(width_i);
          cnt_d      = 3'd0;
          carry_d    = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        res_split[cnt_q] = chunk_sum;
        res_d            = prng_t'(res_split);
        carry_d          = chunk_cout;
        cnt_d            = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // An abandoned pair leaves no trace: everything returns to its idle value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ps_q        <= '0;
      b_q         <= '0;
      w_q         <= '0;
      cnt_q       <= 3'd0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ps_q        <= ps_d;
      b_q         <= b_d;
      w_q         <= w_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign res_o       = res_q;

endmodule

// File: tb/tb_csa_resolve.sv
// Directed and randomized bench for csa_resolve against a per-lane arithmetic model.
module tb_csa_resolve;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready_o;
  logic [255:0] ps_i;
  logic [255:0] sc_i;
  logic [2:0]   width_i;
  logic         out_valid_o;
  logic         out_ready;
  logic [255:0] res_o;

  int checks = 0;
  int passes = 0;

  csa_resolve dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .ps_i        (ps_i),
    .sc_i        (sc_i),
    .width_i     (width_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .res_o       (res_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each lane of W bits is (ps + 2*sc) mod 2^W, computed lane by lane.
  function automatic logic [255:0] modelRes(logic [255:0] ps, logic [255:0] sc, logic [2:0] w);
    int           lw;
    logic [255:0] mask;
    logic [255:0] lane;
    logic [255:0] r;
    lw   = w[2] ? 256 : (w[1] ? 128 : (w[0] ? 64 : 32));
    mask = (lw == 256) ? '1 : ((256'd1 << lw) - 256'd1);
    r    = '0;
    for (int o = 0; o < 256; o += lw) begin
      lane = (((ps >> o) & mask) + (((sc >> o) & mask) << 1)) & mask;
      r    = r | (lane << o);
    end
    return r;
  endfunction

  function automatic logic [255:0] randVec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [255:0] ps, input logic [255:0] sc, input logic [2:0] w);
    int t;
    t = 0;
    while (in_ready_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("accept_ready", 256'(in_ready_o), 256'd1);
    ps_i     = ps;
    sc_i     = sc;
    width_i  = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    width_i  = ~w;
    ps_i     = ~ps;
    sc_i     = ~sc;
  endtask

  task automatic waitResult(output int edges);
    edges = 0;
    while (out_valid_o !== 1'b1 && edges < 30) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic runPair(input string tag, input logic [255:0] ps, input logic [255:0] sc,
                         input logic [2:0] w, input logic [255:0] fixed_exp, input logic use_fixed);
    int edges;
    applyStimulus(ps, sc, w);
    waitResult(edges);
    checkOutput({tag, "_latency"}, 256'(edges), 256'd8);
    checkOutput({tag, "_model"}, res_o, modelRes(ps, sc, w));
    if (use_fixed) checkOutput({tag, "_const"}, res_o, fixed_exp);
    releaseResult();
  endtask

  initial begin
    logic [255:0] all_f;
    logic [255:0] all_1;
    logic [255:0] ps4;
    logic [255:0] bp_exp;
    logic [255:0] rp;
    logic [255:0] rs;
    logic [2:0]   rw;
    int           edges;

    all_f     = {8{32'hFFFFFFFF}};
    all_1     = {8{32'h00000001}};
    ps4       = {128'd0, {4{32'hFFFFFFFF}}};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ps_i      = '0;
    sc_i      = '0;
    width_i   = 3'b000;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 256'(out_valid_o), 256'd0);
    checkOutput("reset_res", res_o, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", 256'(in_ready_o), 256'd1);

    $display("[TB] directed pairs");
    runPair("w32_wrap", all_f, all_1, 3'b000, all_1, 1'b1);
    runPair("w256_ripple", all_f, all_1, 3'b100, {{7{32'h2}}, 32'h1}, 1'b1);
    runPair("topbit_w32", 256'd0, 256'h80000000, 3'b000, 256'd0, 1'b1);
    runPair("topbit_w64", 256'd0, 256'h80000000, 3'b001, 256'd1 << 32, 1'b1);
    runPair("w128_boundary", ps4, 256'd1, 3'b010, 256'd1, 1'b1);
    runPair("w128_lane1", {ps4[127:0], ps4[127:0]}, 256'd1, 3'b010,
            {{4{32'hFFFFFFFF}}, 128'd1}, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(all_f, all_1, 3'b100);
    waitResult(edges);
    checkOutput("bp_latency", 256'(edges), 256'd8);
    bp_exp = modelRes(all_f, all_1, 3'b100);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        ps_i     = 256'd5;
        sc_i     = 256'd7;
        width_i  = 3'b000;
        in_valid = 1'b1;
      end
      @(negedge clk);
      checkOutput("bp_res_stable", res_o, bp_exp);
      checkOutput("bp_in_ready", 256'(in_ready_o), 256'd0);
      checkOutput("bp_out_valid", 256'(out_valid_o), 256'd1);
    end
    in_valid = 1'b0;
    releaseResult();
    checkOutput("bp_release_in_ready", 256'(in_ready_o), 256'd1);
    checkOutput("bp_release_out_valid", 256'(out_valid_o), 256'd0);

    $display("[TB] reset mid-run");
    applyStimulus(all_f, all_1, 3'b100);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 256'(out_valid_o), 256'd0);
    checkOutput("midrst_res", res_o, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runPair("after_reset", all_f, all_1, 3'b000, all_1, 1'b1);

    $display("[TB] random pairs");
    for (int i = 0; i < 16; i++) begin
      rp = randVec();
      rs = randVec();
      rw = 3'($urandom_range(0, 7));
      runPair("random", rp, rs, rw, 256'd0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
